// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_arbiter
// Purpose  : Shares one sequential 8x8 multiplier between NUM_REQ requesters.
//            A round-robin arbiter picks one request and latches its operands.
//            It pulses the multiplier start, then waits for done (with a
//            timeout) and returns the 16-bit product to the winner.
// Ports    : clk, reset_a            clock / synchronous active-high reset
//            req, req_a, req_b       request levels and packed operands
//            ack, rsp_valid          one-hot single-cycle handshakes
//            rsp_product, rsp_error  result and timeout indication
//            busy                    high whenever the FSM is not idle
//            mul_data_a/b, mul_start, mul_done, mul_product
//                                    multiplier interface
// Revision : 1.0  initial release
// ============================================================================
module mult_share_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset_a,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_a,
    input  logic [8*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]     ack,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [15:0]            rsp_product,
    output logic                   rsp_error,
    output logic                   busy,
    output logic [7:0]             mul_data_a,
    output logic [7:0]             mul_data_b,
    output logic                   mul_start,
    input  logic                   mul_done,
    input  logic [15:0]            mul_product
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] r_win;
    logic [7:0]       r_a;
    logic [7:0]       r_b;
    logic [15:0]      r_prod;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic             w_any;
    logic [IDX_W-1:0] w_pick;
    logic [7:0]       w_a;
    logic [7:0]       w_b;
    logic             w_timeout;

    // (base + off) mod NUM_REQ for off in 1..NUM_REQ; avoids a generic divider.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    // Round-robin pick: walk the offsets from farthest to nearest so the
    // nearest set bit after r_last is the one left standing.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req[wrap_idx(r_last, i)]) begin
                w_any  = 1'b1;
                w_pick = wrap_idx(r_last, i);
            end
        end
    end

    // Operand mux for the picked requester.
    always_comb begin
        w_a = 8'd0;
        w_b = 8'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick == IDX_W'(i)) begin
                w_a = req_a[8*i +: 8];
                w_b = req_b[8*i +: 8];
            end
        end
    end

    // Done takes priority over the timeout when both land in the same cycle.
    assign w_timeout = !mul_done && (r_cnt == C_TIMEOUT);

    // State register
    always_ff @(posedge clk) begin
        if (reset_a) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        mul_start   = 1'b0;
        ack         = '0;
        rsp_valid   = '0;
        rsp_error   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) w_state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                mul_start   = 1'b1;
                ack[r_win]  = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mul_done || w_timeout) w_state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid[r_win] = 1'b1;
                rsp_error        = r_err;
                w_state_nxt      = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: winner, operands, wait counter, result capture
    always_ff @(posedge clk) begin
        if (reset_a) begin
            r_last <= IDX_W'(NUM_REQ - 1);
            r_win  <= '0;
            r_a    <= 8'd0;
            r_b    <= 8'd0;
            r_prod <= 16'd0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_win  <= w_pick;
                        r_last <= w_pick;
                        r_a    <= w_a;
                        r_b    <= w_b;
                        r_err  <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    // First WAIT cycle is counted as 1.
                    r_cnt <= CNT_W'(1);
                end
                S_WAIT: begin
                    if (mul_done) begin
                        r_prod <= mul_product;
                    end else if (w_timeout) begin
                        r_prod <= 16'd0;
                        r_err  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign rsp_product = r_prod;
    assign mul_data_a  = r_a;
    assign mul_data_b  = r_b;

endmodule
`default_nettype wire
